// File: rtl/seven_seg_scan_reader.sv
// Recovers hex digits from a scanned 7-segment bus. Each stable digit period yields
// at most one capture, and a completed set of captures is published as a frame.
module seven_seg_scan_reader #(
  parameter int NUM_DIG    = 4,
  parameter int STABLE_CYC = 4
) (
  input  logic                 clk,
  input  logic                 rst_x,
  input  logic [7:0]           seg_in,
  input  logic [NUM_DIG-1:0]   dig_sel,
  output logic [4*NUM_DIG-1:0] value,
  output logic [NUM_DIG-1:0]   dots,
  output logic [NUM_DIG-1:0]   bad,
  output logic                 frame_valid,
  output logic                 sel_err
);

  localparam int CW = $clog2(STABLE_CYC + 1);

  typedef enum logic {SETTLE = 1'b0, HELD = 1'b1} state_t;

  state_t                 state_r;
  logic [7:0]             seg_r;
  logic [NUM_DIG-1:0]     sel_r;
  logic [CW-1:0]          cnt_r;
  logic [4*NUM_DIG-1:0]   shad_val_r;
  logic [NUM_DIG-1:0]     shad_dot_r;
  logic [NUM_DIG-1:0]     shad_bad_r;
  logic [NUM_DIG-1:0]     seen_r;

  logic [4:0]             dec_s;
  logic                   chg_s;
  logic                   onehot_s;
  logic                   act_s;
  logic [NUM_DIG-1:0]     cap_mask_s;
  logic [NUM_DIG-1:0]     seen_nxt_s;

  // Returns {bad, nibble}; unrecognised patterns map to nibble 0 with bad set.
  function automatic logic [4:0] decode_glyph(input logic [6:0] pat);
    case (pat)
      7'h3F:   return {1'b0, 4'h0};
      7'h06:   return {1'b0, 4'h1};
      7'h5B:   return {1'b0, 4'h2};
      7'h4F:   return {1'b0, 4'h3};
      7'h66:   return {1'b0, 4'h4};
      7'h6D:   return {1'b0, 4'h5};
      7'h7D:   return {1'b0, 4'h6};
      7'h07:   return {1'b0, 4'h7};
      7'h7F:   return {1'b0, 4'h8};
      7'h6F:   return {1'b0, 4'h9};
      7'h77:   return {1'b0, 4'hA};
      7'h7C:   return {1'b0, 4'hB};
      7'h39:   return {1'b0, 4'hC};
      7'h5E:   return {1'b0, 4'hD};
      7'h79:   return {1'b0, 4'hE};
      7'h71:   return {1'b0, 4'hF};
      default: return {1'b1, 4'h0};
    endcase
  endfunction

  // Change detection, settle decision and next seen set.
  always_comb begin
    dec_s    = decode_glyph(seg_r[6:0]);
    chg_s    = (seg_in != seg_r) || (dig_sel != sel_r);
    onehot_s = (sel_r != {NUM_DIG{1'b0}}) &&
               ((sel_r & (sel_r - NUM_DIG'(1))) == {NUM_DIG{1'b0}});
    // Act on the edge where the count would reach STABLE_CYC with the input still unchanged.
    act_s    = (state_r == SETTLE) && !chg_s && (cnt_r == CW'(STABLE_CYC - 1));
    if (act_s && onehot_s) begin
      cap_mask_s = sel_r;
    end else begin
      cap_mask_s = {NUM_DIG{1'b0}};
    end
    if (&seen_r) begin
      seen_nxt_s = cap_mask_s;
    end else begin
      seen_nxt_s = seen_r | cap_mask_s;
    end
  end

  // Input stage, stability counter, settle/held FSM, shadow capture and frame publish.
  always_ff @(posedge clk) begin
    if (rst_x) begin
      state_r     <= SETTLE;
      seg_r       <= 8'h00;
      sel_r       <= {NUM_DIG{1'b0}};
      cnt_r       <= {CW{1'b0}};
      shad_val_r  <= {(4*NUM_DIG){1'b0}};
      shad_dot_r  <= {NUM_DIG{1'b0}};
      shad_bad_r  <= {NUM_DIG{1'b0}};
      seen_r      <= {NUM_DIG{1'b0}};
      value       <= {(4*NUM_DIG){1'b0}};
      dots        <= {NUM_DIG{1'b0}};
      bad         <= {NUM_DIG{1'b0}};
      frame_valid <= 1'b0;
      sel_err     <= 1'b0;
    end else begin
      seg_r <= seg_in;
      sel_r <= dig_sel;
      if (chg_s) begin
        cnt_r <= {CW{1'b0}};
      end else if (cnt_r != CW'(STABLE_CYC)) begin
        cnt_r <= cnt_r + CW'(1);
      end else begin
        cnt_r <= cnt_r;
      end

      case (state_r)
        SETTLE:  state_r <= act_s ? HELD : SETTLE;
        HELD:    state_r <= chg_s ? SETTLE : HELD;
        default: state_r <= SETTLE;
      endcase

      sel_err <= act_s && !onehot_s && (sel_r != {NUM_DIG{1'b0}});

      for (int i = 0; i < NUM_DIG; i++) begin
        if (cap_mask_s[i]) begin
          shad_val_r[4*i +: 4] <= dec_s[3:0];
          shad_dot_r[i]        <= seg_r[7];
          shad_bad_r[i]        <= dec_s[4];
        end
      end
      seen_r <= seen_nxt_s;

      frame_valid <= &seen_r;
      if (&seen_r) begin
        value <= shad_val_r;
        dots  <= shad_dot_r;
        bad   <= shad_bad_r;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_reader.sv
// Bench for seven_seg_scan_reader: directed and random scan dwells checked each cycle
// against a run-length reference model of settle, capture and frame assembly.
module tb_seven_seg_scan_reader;

  localparam int ND = 4;
  localparam int SC = 4;

  logic          clk = 1'b0;
  logic          rst_x;
  logic [7:0]    seg_in;
  logic [ND-1:0] dig_sel;
  logic [4*ND-1:0] value;
  logic [ND-1:0] dots;
  logic [ND-1:0] bad;
  logic          frame_valid;
  logic          sel_err;

  seven_seg_scan_reader #(.NUM_DIG(ND), .STABLE_CYC(SC)) dut (
    .clk(clk), .rst_x(rst_x), .seg_in(seg_in), .dig_sel(dig_sel),
    .value(value), .dots(dots), .bad(bad),
    .frame_valid(frame_valid), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  int edges = 0;
  always @(posedge clk) edges <= edges + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at edge %0d: got %0h expected %0h", tag, edges, got, exp);
  endtask

  // Reference model state
  logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  typedef struct { int at; logic [4*ND-1:0] v; logic [ND-1:0] d; logic [ND-1:0] b; } frame_t;
  frame_t fq[$];
  int     eq[$];
  logic [4*ND-1:0] m_val;
  logic [ND-1:0]   m_dots, m_bad, m_seen;
  logic [7:0]      run_seg;
  logic [ND-1:0]   run_sel;
  int              run_start, run_len;
  bit              run_fired;

  function automatic logic [4:0] ref_decode(input logic [6:0] p);
    for (int g = 0; g < 16; g++) if (glyph_tab[g] == p) return {1'b0, 4'(g)};
    return 5'b10000;
  endfunction

  // A settled run acts on edge `at`: capture one digit, or flag a bad select.
  task automatic model_act(input int at);
    logic [4:0] dc;
    frame_t f;
    if ($countones(run_sel) == 1) begin
      for (int i = 0; i < ND; i++) begin
        if (run_sel[i]) begin
          dc = ref_decode(run_seg[6:0]);
          m_val[4*i +: 4] = dc[3:0];
          m_bad[i]  = dc[4];
          m_dots[i] = run_seg[7];
          m_seen[i] = 1'b1;
        end
      end
      if (&m_seen) begin
        f.at = at + 1; f.v = m_val; f.d = m_dots; f.b = m_bad;
        fq.push_back(f);
        m_seen = '0;
      end
    end else if (run_sel != '0) begin
      eq.push_back(at);
    end
  endtask

  // Drive one value for len sampling edges; called at a negedge.
  task automatic dwell(input logic [7:0] s, input logic [ND-1:0] d, input int len);
    seg_in  = s;
    dig_sel = d;
    if (s == run_seg && d == run_sel) begin
      run_len += len;
    end else begin
      run_seg = s; run_sel = d; run_start = edges + 1; run_len = len; run_fired = 1'b0;
    end
    if (!run_fired && run_len >= SC + 1) begin
      run_fired = 1'b1;
      model_act(run_start + SC);
    end
    repeat (len) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    int first;
    rst_x = 1'b1; seg_in = 8'h00; dig_sel = '0;
    first = edges + 1;
    while (fq.size() > 0 && fq[fq.size()-1].at >= first) void'(fq.pop_back());
    while (eq.size() > 0 && eq[eq.size()-1] >= first) void'(eq.pop_back());
    m_val = '0; m_dots = '0; m_bad = '0; m_seen = '0;
    run_seg = 8'h00; run_sel = '0; run_start = first; run_len = 0; run_fired = 1'b1;
    repeat (n) @(negedge clk);
    rst_x = 1'b0;
  endtask

  // Per-cycle expected outputs, sampled 1 time unit after each rising edge.
  logic [4*ND-1:0] exp_v = '0;
  logic [ND-1:0]   exp_d = '0, exp_b = '0;
  logic            exp_fv, exp_err;
  always @(posedge clk) begin
    #1;
    exp_fv  = 1'b0;
    exp_err = 1'b0;
    if (rst_x) begin
      exp_v = '0; exp_d = '0; exp_b = '0;
    end else begin
      if (fq.size() > 0 && fq[0].at == edges) begin
        exp_fv = 1'b1; exp_v = fq[0].v; exp_d = fq[0].d; exp_b = fq[0].b;
        void'(fq.pop_front());
      end
      if (eq.size() > 0 && eq[0] == edges) begin
        exp_err = 1'b1;
        void'(eq.pop_front());
      end
    end
    check_eq("frame_valid", 32'(frame_valid), 32'(exp_fv));
    check_eq("sel_err", 32'(sel_err), 32'(exp_err));
    check_eq("value", 32'(value), 32'(exp_v));
    check_eq("dots", 32'(dots), 32'(exp_d));
    check_eq("bad", 32'(bad), 32'(exp_b));
  end

  logic [7:0] pat_tab [4] = '{8'h4F, 8'h66, 8'h6D, 8'hF9};

  initial begin
    int dig;
    int len;
    logic [7:0] s;
    logic [ND-1:0] d;
    rst_x = 1'b1; seg_in = 8'h00; dig_sel = '0;
    do_reset(3);

    // Basic frame, including a dot on one digit
    for (int i = 0; i < ND; i++) dwell(pat_tab[i], ND'(1) << i, 6);
    dwell(8'h00, '0, 4);

    // Glitch inside a digit-1 dwell, digit 2 held long, illegal pattern on digit 0
    dwell(8'h3F, 4'b0001, 6);
    dwell(8'h06, 4'b0010, 3);
    dwell(8'h7F, 4'b0010, 2);
    dwell(8'h06, 4'b0010, 6);
    dwell(8'h5B, 4'b0100, 50);
    dwell(8'h4F, 4'b1000, 6);
    dwell(8'h00, 4'b0001, 6);
    dwell(8'h66, 4'b0010, 6);
    dwell(8'h6D, 4'b0100, 6);
    dwell(8'h7D, 4'b1000, 6);
    dwell(8'h00, '0, 4);

    // Non-one-hot select, then a short-of-threshold dwell
    dwell(8'h07, 4'b0110, 5);
    dwell(8'h77, 4'b0001, SC);
    dwell(8'h00, '0, 4);

    // Reset after three captures, then a full scan
    for (int i = 0; i < 3; i++) dwell(pat_tab[i], ND'(1) << i, 6);
    do_reset(4);
    for (int i = 0; i < ND; i++) dwell({1'b1, glyph_tab[i + 8]}, ND'(1) << i, SC + 1);
    dwell(8'h00, '0, 4);

    // Randomized scanning
    dig = 0;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 99) < 85) s = {1'($urandom_range(0, 1)), glyph_tab[$urandom_range(0, 15)]};
      else s = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 19))
        0:       d = '0;
        1:       d = ND'($urandom_range(0, 15));
        default: begin d = ND'(1) << dig; dig = (dig + 1) % ND; end
      endcase
      if ($urandom_range(0, 9) < 7) len = $urandom_range(SC + 1, SC + 4);
      else len = $urandom_range(1, SC);
      dwell(s, d, len);
      if ($urandom_range(0, 99) < 2) do_reset($urandom_range(1, 3));
    end
    dwell(8'h00, '0, 10);

    check_eq("frames_drained", 32'(fq.size()), 32'd0);
    check_eq("errs_drained", 32'(eq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
